// File: rtl/muldiv_if.sv
// Request/response bundle between EX stage and the mult/div unit.
// master: EX side (Start/Op/A/B/Flush out); slave: unit (Busy/Hi/Lo out).
interface muldiv_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, A, B, Flush,
        input  Busy, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, Flush,
        output Busy, Hi, Lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning architectural HI/LO.
// Ports: Clk, Reset (async high), bus (muldiv_if.slave).
module muldiv_unit (
    input  logic     Clk,
    input  logic     Reset,
    muldiv_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    // Multiply: {acc, multiplier}; divide: {remainder, dividend/quotient}
    logic [63:0] p_q;
    // Multiplicand magnitude or divisor magnitude
    logic [31:0] m_q;
    logic        is_div_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic        div0_q;
    logic [31:0] a_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_md;
    logic        is_sgn;
    logic        is_dv;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_sh;
    logic [33:0] div_df;
    logic [63:0] div_nxt;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        is_md  = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU) ||
                 (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
        is_sgn = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
        is_dv  = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
        a_mag  = (is_sgn && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
        b_mag  = (is_sgn && bus.B[31]) ? (32'd0 - bus.B) : bus.B;
    end

    always_comb begin
        // Shift-add: carry out of the add becomes the new MSB
        mul_sum = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
        mul_nxt = {mul_sum, p_q[31:1]};
        // Restoring step: bring next dividend bit into remainder
        div_sh  = {p_q[63:32], p_q[31]};
        div_df  = {1'b0, div_sh} - {2'b00, m_q};
        div_nxt = div_df[33] ? {div_sh[31:0], p_q[30:0], 1'b0}
                             : {div_df[31:0], p_q[30:0], 1'b1};
        prod    = neg_q_q ? (64'd0 - p_q) : p_q;
        quot    = neg_q_q ? (32'd0 - p_q[31:0]) : p_q[31:0];
        rem     = neg_r_q ? (32'd0 - p_q[63:32]) : p_q[63:32];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            p_q      <= 64'd0;
            m_q      <= 32'd0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.Start && !bus.Flush) begin
                        if (is_md) begin
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            cnt_q    <= 5'd31;
                            p_q      <= {32'd0, is_dv ? a_mag : b_mag};
                            m_q      <= is_dv ? b_mag : a_mag;
                            is_div_q <= is_dv;
                            neg_q_q  <= is_sgn & (bus.A[31] ^ bus.B[31]);
                            neg_r_q  <= is_sgn & bus.A[31];
                            div0_q   <= (bus.B == 32'd0);
                            a_q      <= bus.A;
                        end else if (bus.Op == OP_MTHI) begin
                            hi_q <= bus.A;
                        end else if (bus.Op == OP_MTLO) begin
                            lo_q <= bus.A;
                        end
                    end
                end
                RUN: begin
                    if (bus.Flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        p_q   <= is_div_q ? div_nxt : mul_nxt;
                        cnt_q <= cnt_q - 5'd1;
                        if (cnt_q == 5'd0) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!bus.Flush) begin
                        if (!is_div_q) begin
                            hi_q <= prod[63:32];
                            lo_q <= prod[31:0];
                        end else if (div0_q) begin
                            hi_q <= a_q;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= rem;
                            lo_q <= quot;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Drives via muldiv_if; samples 1 time unit after each rising edge.
module tb_muldiv_unit;
    logic Clk;
    logic Reset;
    int   tests;
    int   fails;
    int   n;

    muldiv_if bus ();

    muldiv_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch op, then count Busy cycles until it drops (bounded)
    task automatic run_op(input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        n = 0;
        while (bus.Busy && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.Flush = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_hi", bus.Hi, 32'd0);
        check("rst_lo", bus.Lo, 32'd0);
        #12;
        Reset = 1'b0;
        step();

        run_op(3'b001, 32'hFFFF_FFFE, 32'd7);
        check("mult_lat", n, 32'd33);
        check("mult_hi", bus.Hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.Lo, 32'hFFFF_FFF2);

        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_lat", n, 32'd33);
        check("multu_hi", bus.Hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.Lo, 32'h0000_0001);

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mult_m1_hi", bus.Hi, 32'h0);
        check("mult_m1_lo", bus.Lo, 32'h1);

        run_op(3'b011, 32'hFFFF_FFF9, 32'd2);
        check("div_lat", n, 32'd33);
        check("div_lo", bus.Lo, 32'hFFFF_FFFD);
        check("div_hi", bus.Hi, 32'hFFFF_FFFF);

        run_op(3'b100, 32'd100, 32'd0);
        check("divu0_lat", n, 32'd33);
        check("divu0_lo", bus.Lo, 32'hFFFF_FFFF);
        check("divu0_hi", bus.Hi, 32'd100);

        run_op(3'b011, 32'hFFFF_FFFB, 32'd0);
        check("div0_lo", bus.Lo, 32'hFFFF_FFFF);
        check("div0_hi", bus.Hi, 32'hFFFF_FFFB);

        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divov_lo", bus.Lo, 32'h8000_0000);
        check("divov_hi", bus.Hi, 32'h0);

        run_op(3'b100, 32'd1000, 32'd7);
        check("divu_lo", bus.Lo, 32'd142);
        check("divu_hi", bus.Hi, 32'd6);

        // MTHI: one-cycle write, no Busy
        bus.Start = 1'b1;
        bus.Op    = 3'b101;
        bus.A     = 32'hDEAD_BEEF;
        step();
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        check("mthi_hi", bus.Hi, 32'hDEAD_BEEF);
        check("mthi_lo", bus.Lo, 32'd142);
        check("mthi_busy", {31'd0, bus.Busy}, 32'd0);

        // MULTU with an MTLO attempted mid-flight
        bus.Start = 1'b1;
        bus.Op    = 3'b010;
        bus.A     = 32'h0001_0000;
        bus.B     = 32'h0003_0003;
        step();
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        for (int i = 0; i < 9; i++) step();
        check("busy_mid", {31'd0, bus.Busy}, 32'd1);
        bus.Start = 1'b1;
        bus.Op    = 3'b110;
        bus.A     = 32'd5;
        step();
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        check("mtlo_ign_lo", bus.Lo, 32'd142);
        check("hi_hold_busy", bus.Hi, 32'hDEAD_BEEF);
        n = 0;
        while (bus.Busy && n < 100) begin
            n++;
            step();
        end
        check("mtlo_ign_busy", {31'd0, bus.Busy}, 32'd0);
        check("mtlo_ign_hi", bus.Hi, 32'h0000_0003);
        check("mtlo_ign_lo2", bus.Lo, 32'h0003_0000);

        // Flush mid-DIVU
        bus.Start = 1'b1;
        bus.Op    = 3'b100;
        bus.A     = 32'd1000;
        bus.B     = 32'd7;
        step();
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        for (int i = 0; i < 14; i++) step();
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        check("flush_busy", {31'd0, bus.Busy}, 32'd0);
        check("flush_hi", bus.Hi, 32'h0000_0003);
        check("flush_lo", bus.Lo, 32'h0003_0000);
        for (int i = 0; i < 40; i++) step();
        check("flush_hi_late", bus.Hi, 32'h0000_0003);
        check("flush_lo_late", bus.Lo, 32'h0003_0000);

        // Flush beats Start in IDLE
        bus.Flush = 1'b1;
        bus.Start = 1'b1;
        bus.Op    = 3'b101;
        bus.A     = 32'd123;
        step();
        check("fl_mthi_hi", bus.Hi, 32'h0000_0003);
        bus.Op = 3'b001;
        step();
        check("fl_mult_busy", {31'd0, bus.Busy}, 32'd0);
        bus.Flush = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        step();
        check("fl_idle_busy", {31'd0, bus.Busy}, 32'd0);

        // Async reset mid-MULT
        bus.Start = 1'b1;
        bus.Op    = 3'b001;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        step();
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        for (int i = 0; i < 4; i++) step();
        #2;
        Reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.Busy}, 32'd0);
        check("arst_hi", bus.Hi, 32'd0);
        check("arst_lo", bus.Lo, 32'd0);
        #10;
        Reset = 1'b0;
        step();

        run_op(3'b010, 32'd6, 32'd7);
        check("post_rst_lo", bus.Lo, 32'd42);
        check("post_rst_hi", bus.Hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit that owns the architectural HI/LO registers for the MIPS III pipeline. The EX stage launches MULT/MULTU/DIV/DIVU/MTHI/MTLO here. The unit supplies the HI/LO values that `alu` returns for MFHI/MFLO, and the Busy indication the hazard unit uses to stall MFHI/MFLO and further mult/div issue. It is the producer side of the HI/LO path that the ALU consumes.

## Interface
- No parameters; datapath is fixed at 32 bits.
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  launch the operation in Op this cycle; honoured only when Busy=0
- Op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 reserved, treated as none
- A  input  32  rs operand (multiplicand / dividend / MTHI/MTLO data)
- B  input  32  rt operand (multiplier / divisor)
- Flush  input  1  abort any in-flight operation; HI/LO keep prior values
- Busy  output  1  operation in flight; hazard unit stalls MFHI/MFLO and mult/div issue
- Hi  output  32  architectural HI register
- Lo  output  32  architectural LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE, Start=1, Op MULT..DIVU:
  - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned.
  - Latch result-sign flags: quotient/product sign = A[31]^B[31]; remainder sign = A[31].
  - Clear the 64-bit accumulator, load iteration counter = 31, go to RUN.
- RUN, multiply: one radix-2 shift-add step per cycle on a 64-bit {acc, multiplier} register.
- RUN, divide: one restoring step per cycle (shift remainder, trial-subtract divisor, set quotient bit).
- RUN: counter decrements each cycle; when counter=0, go to FIX on the next edge.
- FIX: apply two's-complement negation where the sign flag requires it, then write results.
  - Multiply: Hi = product[63:32], Lo = product[31:0].
  - Divide: Lo = quotient, Hi = remainder.
  - Go to IDLE.
- Divide by zero (B=0), signed and unsigned: Lo = 32'hFFFF_FFFF, Hi = original A. Latency is unchanged.
- Signed overflow (A=32'h8000_0000, B=32'hFFFF_FFFF): Lo = 32'h8000_0000, Hi = 0.
- MTHI/MTLO with Start=1 in IDLE: Hi (or Lo) = A at the next edge; no state change; Busy stays 0.
- Start while Busy=1: ignored entirely; no state, operand, or HI/LO change.
- Flush in RUN or FIX: go to IDLE at the next edge; HI/LO not written.
- Flush and Start in the same IDLE cycle: Flush wins; nothing launches, MTHI/MTLO included.
- Multiply is exact over the full 64-bit signed/unsigned product range, with no wrap.

## Timing
- Reset, asynchronous: state=IDLE, counter=0, Busy=0, Hi=0, Lo=0, internal datapath registers 0.
- Busy is a registered output equal to (state != IDLE). It has no combinational path from Start.
- Start on edge N:
  - RUN covers edges N+1..N+32.
  - FIX writes HI/LO at edge N+33.
  - Busy=1 from after edge N through edge N+33, which is 33 cycles.
- Hi/Lo are valid the first cycle Busy reads 0 again.
- Next Start may be accepted in the first cycle Busy=0.
- MTHI/MTLO latency: 1 cycle.
- Hi/Lo change only on a FIX write, MTHI/MTLO, or reset. They are stable and readable at all other times, including while Busy=1; the hazard unit forbids reading them then.
- Reset asserted mid-operation: outputs return to reset values immediately, with no wait for a clock edge.

## Test plan
- MULT A=32'hFFFF_FFFE (-2), B=7 → after 33 Busy cycles: Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFF2.
- MULTU A=B=32'hFFFF_FFFF → Hi=32'hFFFF_FFFE, Lo=32'h0000_0001. Same operands with MULT → Hi=0, Lo=1.
- DIV A=-7 (32'hFFFF_FFF9), B=2 → Lo=32'hFFFF_FFFD (-3), Hi=32'hFFFF_FFFF (-1).
  - DIVU A=100, B=0 → Lo=32'hFFFF_FFFF, Hi=100.
  - DIV A=32'h8000_0000, B=-1 → Lo=32'h8000_0000, Hi=0.
- MTHI A=32'hDEAD_BEEF → Hi updated next edge, Busy never rises. Then start MULTU, and on cycle 10 issue Start with MTLO A=5 → ignored; final Lo is the product.
- Start DIVU, assert Flush at cycle 15 → Busy=0 next cycle, Hi/Lo unchanged. Then assert Reset asynchronously mid-MULT → Busy, Hi, Lo = 0 before the next Clk edge.
